// File: rtl/imem_pkg.sv
// ----------------------------------------------------------------------------
// imem_pkg
// Shared types and helpers for the instruction memory block.
//   mode_e      : RUN (fetches served) / LOAD (byte loader owns the array)
//   NBYTES/OFFW : bytes per fetch word and offset width for the default
//                 32-bit fetch word
//   is_aligned  : true when the low offw bits of a byte address are zero
// ----------------------------------------------------------------------------
package imem_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } mode_e;

  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned NBYTES     = DWIDTH_DEF / 8;
  localparam int unsigned OFFW       = $clog2(NBYTES);

  // offw defaults to the package word size; the top passes its own
  // parameter-derived value so other DWIDTH choices stay consistent.
  function automatic logic is_aligned(input logic [31:0] addr,
                                      input int unsigned offw = OFFW);
    logic [31:0] mask;
    mask = (32'd1 << offw) - 32'd1;
    return ((addr & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// ----------------------------------------------------------------------------
// imem_byte_array
// 2**AWIDTH x 8 byte storage with one write port and an NBYTES-wide
// little-endian combinational gather read starting at i_raddr.
// Contents are deliberately not reset.
//   clk      : clock
//   i_we     : byte write enable
//   i_waddr  : byte write address
//   i_wdata  : byte write data
//   i_raddr  : base byte address of the gather read
//   o_rdata  : {mem[raddr+NBYTES-1], ..., mem[raddr]}
// ----------------------------------------------------------------------------
module imem_byte_array
  import imem_pkg::*;
#(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AWIDTH-1:0]     i_waddr,
  input  logic [7:0]            i_wdata,
  input  logic [AWIDTH-1:0]     i_raddr,
  output logic [NBYTES*8-1:0]   o_rdata
);

  logic [7:0] r_mem [2**AWIDTH];

  // Byte write port; storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Gather NBYTES consecutive bytes, lowest address into the low byte.
  // Index math stays at AWIDTH bits; aligned bases never reach the wrap.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      o_rdata[i*8 +: 8] = r_mem[i_raddr + AWIDTH'(i)];
    end
  end

endmodule

// File: rtl/imem_rom.sv
// ----------------------------------------------------------------------------
// imem_rom
// Byte-addressed, little-endian instruction memory with a registered read
// path, valid/ready request/response handshake, misalignment detection and
// a byte-wide run-time loader.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/req_ready   : fetch request handshake
//   req_addr              : fetch byte address
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata             : fetched word (byte at req_addr in [7:0])
//   rsp_err               : fetch was misaligned (rsp_rdata is then 0)
//   ld_en / ld_ack        : loader mode request / loader mode active
//   ld_we, ld_addr,
//   ld_wdata              : loader byte write
// ----------------------------------------------------------------------------
module imem_rom
  import imem_pkg::*;
#(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AWIDTH-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ld_en,
  output logic              ld_ack,
  input  logic              ld_we,
  input  logic [AWIDTH-1:0] ld_addr,
  input  logic [7:0]        ld_wdata
);

  localparam int unsigned L_NBYTES  = DWIDTH / 8;
  localparam int unsigned L_OFFW    = $clog2(L_NBYTES);
  localparam logic [AWIDTH-1:0] L_OFFMASK = AWIDTH'((1 << L_OFFW) - 1);

  mode_e             r_state;
  logic              r_rsp_valid;
  logic [DWIDTH-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_aligned;
  logic              w_mem_we;
  logic [AWIDTH-1:0] w_rd_base;
  logic [DWIDTH-1:0] w_gather;

  // Fetches are refused the moment ld_en rises, before LOAD is reached,
  // so the array is never read and written in the same cycle.
  assign w_req_ready = (r_state == RUN) && !ld_en && (!r_rsp_valid || rsp_ready);
  assign w_accept    = req_valid && w_req_ready;
  assign w_aligned   = is_aligned(32'(req_addr), L_OFFW);
  assign w_mem_we    = (r_state == LOAD) && ld_we;
  // Offset bits forced low; the gathered word is discarded when misaligned.
  assign w_rd_base   = req_addr & ~L_OFFMASK;

  imem_byte_array #(
    .AWIDTH (AWIDTH),
    .NBYTES (L_NBYTES)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_wdata),
    .i_raddr (w_rd_base),
    .o_rdata (w_gather)
  );

  // Mode FSM and response register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        // Enter LOAD only once no response is left behind.
        RUN: begin
          if (ld_en && (!r_rsp_valid || rsp_ready)) begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (!ld_en) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase

      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_aligned ? w_gather : '0;
        r_rsp_err   <= !w_aligned;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign ld_ack    = (r_state == LOAD);

endmodule
